// File: rtl/booth_mul_seq.sv
// Sequential signed radix-2 Booth multiplier for the ALU mul operation.
// It performs one Booth step per clock and returns a registered HI/LO product with a one-cycle finished pulse.
module booth_mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             busy,
    output logic             finished
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on the accepting edge
    // RUN   | one Booth add/sub plus arithmetic shift per edge, WIDTH edges total
    // DONE  | one cycle; finished high, results valid
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int PW = 2*WIDTH + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH:0]   m_q;
    logic [PW-1:0]    p_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_hi_q;
    logic [WIDTH-1:0] result_lo_q;
    logic             busy_q;
    logic             finished_q;

    logic [WIDTH:0]   upper;
    logic [WIDTH:0]   upper_sum;
    logic [PW-1:0]    p_shift;
    logic             last_step;

    // State register
    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The upper accumulator is one bit wider than an operand so that the most negative multiplicand cannot overflow.
    always_comb begin
        upper     = p_q[PW-1:WIDTH+1];
        upper_sum = upper;
        case (p_q[1:0])
            2'b01:   upper_sum = upper + m_q;
            2'b10:   upper_sum = upper - m_q;
            default: upper_sum = upper;
        endcase
        p_shift   = {upper_sum[WIDTH], upper_sum, p_q[WIDTH:1]};
        last_step = (cnt_q == LAST_CNT);
    end

    // Datapath and registered status
    always_ff @(posedge Clock) begin
        if (clear) begin
            m_q         <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            result_hi_q <= '0;
            result_lo_q <= '0;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            busy_q     <= (state_d != IDLE);
            finished_q <= (state_d == DONE);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q   <= {A[WIDTH-1], A};
                        p_q   <= {{(WIDTH+1){1'b0}}, B, 1'b0};
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    p_q   <= p_shift;
                    cnt_q <= cnt_q + 1'b1;
                    // Bit 2*WIDTH+1 only duplicates the sign, so the product occupies bits [2*WIDTH:1].
                    if (last_step) begin
                        result_hi_q <= p_shift[2*WIDTH:WIDTH+1];
                        result_lo_q <= p_shift[WIDTH:1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        result_hi = result_hi_q;
        result_lo = result_lo_q;
        busy      = busy_q;
        finished  = finished_q;
    end

endmodule
